// File: rtl/axi_data_upsizer.sv
// Packs NARROW_DW valid/ready beats into WIDE_DW words, little-endian lanes; i_wr_last closes a word early.
// Latency: word valid one edge after its completing beat, when the output register is free or draining.
// Backpressure: holds up to two words (accumulator + output reg); o_wr_ready follows i_rd_ready combinationally.
module axi_data_upsizer #(
    parameter int NARROW_DW = 32,
    parameter int RATIO     = 4,
    parameter int WIDE_DW   = NARROW_DW * RATIO,
    parameter int LW        = $clog2(RATIO)
) (
    input  logic                 i_axi_aclk,
    input  logic                 i_axi_aresetn,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [NARROW_DW-1:0] i_wr_data,
    input  logic                 i_wr_last,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [WIDE_DW-1:0]   o_rd_data,
    output logic [RATIO-1:0]     o_rd_strb,
    output logic                 o_rd_last
);

    logic                 rst_done;
    logic [WIDE_DW-1:0]   r_acc;
    logic [RATIO-1:0]     r_acc_strb;
    logic [LW-1:0]        r_lane;
    logic                 r_acc_last;
    logic                 r_acc_full;

    logic                 in_xfer;
    logic                 out_xfer;
    logic                 acc_move;
    logic                 beat_done;
    logic [WIDE_DW-1:0]   acc_nxt;
    logic [RATIO-1:0]     strb_nxt;

    always_comb begin
        acc_move   = r_acc_full & (~o_rd_valid | i_rd_ready);
        o_wr_ready = rst_done & (~r_acc_full | acc_move);
        in_xfer    = i_wr_valid & o_wr_ready;
        out_xfer   = o_rd_valid & i_rd_ready;
        beat_done  = (r_lane == LW'(RATIO - 1)) | i_wr_last;

        // Lane 0 opens a fresh word, so stale lanes of the previous word are dropped here.
        acc_nxt  = (r_lane == '0) ? '0 : r_acc;
        strb_nxt = (r_lane == '0) ? '0 : r_acc_strb;
        for (int n = 0; n < RATIO; n++) begin
            if (r_lane == LW'(n)) begin
                acc_nxt[n*NARROW_DW +: NARROW_DW] = i_wr_data;
                strb_nxt[n]                       = 1'b1;
            end
        end
    end

    always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            r_acc      <= '0;
            r_acc_strb <= '0;
            r_lane     <= '0;
            r_acc_last <= 1'b0;
            r_acc_full <= 1'b0;
        end else begin
            if (acc_move) begin
                r_acc_full <= 1'b0;
            end
            // A completing beat in the same cycle as a move re-fills the accumulator.
            if (in_xfer) begin
                r_acc      <= acc_nxt;
                r_acc_strb <= strb_nxt;
                if (beat_done) begin
                    r_acc_full <= 1'b1;
                    r_acc_last <= i_wr_last;
                    r_lane     <= '0;
                end else begin
                    r_lane     <= r_lane + LW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_axi_aclk or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            o_rd_strb  <= '0;
            o_rd_last  <= 1'b0;
        end else if (acc_move) begin
            o_rd_valid <= 1'b1;
            o_rd_data  <= r_acc;
            o_rd_strb  <= r_acc_strb;
            o_rd_last  <= r_acc_last;
        end else if (out_xfer) begin
            o_rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_data_upsizer.sv
// Directed bench for axi_data_upsizer (32-bit beats, ratio 4) with hand-computed expected words.
module tb_axi_data_upsizer;

    localparam int NDW = 32;
    localparam int R   = 4;
    localparam int WDW = NDW * R;

    logic            i_axi_aclk = 1'b0;
    logic            i_axi_aresetn = 1'b0;
    logic            i_wr_valid;
    logic            o_wr_ready;
    logic [NDW-1:0]  i_wr_data;
    logic            i_wr_last;
    logic            o_rd_valid;
    logic            i_rd_ready;
    logic [WDW-1:0]  o_rd_data;
    logic [R-1:0]    o_rd_strb;
    logic            o_rd_last;

    typedef struct packed {
        logic [WDW-1:0] d;
        logic [R-1:0]   s;
        logic           l;
    } word_t;

    word_t got_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_acc;
    int    n_stall;
    int    b;

    always #5 i_axi_aclk = ~i_axi_aclk;

    axi_data_upsizer #(.NARROW_DW(NDW), .RATIO(R)) dut (
        .i_axi_aclk    (i_axi_aclk),
        .i_axi_aresetn (i_axi_aresetn),
        .i_wr_valid    (i_wr_valid),
        .o_wr_ready    (o_wr_ready),
        .i_wr_data     (i_wr_data),
        .i_wr_last     (i_wr_last),
        .o_rd_valid    (o_rd_valid),
        .i_rd_ready    (i_rd_ready),
        .o_rd_data     (o_rd_data),
        .o_rd_strb     (o_rd_strb),
        .o_rd_last     (o_rd_last)
    );

    // Inputs change just after posedge, so the negedge sees exactly what the next edge will take.
    always @(negedge i_axi_aclk) begin
        if (i_axi_aresetn && o_rd_valid && i_rd_ready)
            got_q.push_back(word_t'({o_rd_data, o_rd_strb, o_rd_last}));
    end

    task automatic check(input string tag, input logic [WDW-1:0] got, input logic [WDW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic beat(input logic [NDW-1:0] d, input logic l);
        logic acc;
        int   t;
        t          = 0;
        i_wr_valid = 1'b1;
        i_wr_data  = d;
        i_wr_last  = l;
        do begin
            @(negedge i_axi_aclk);
            acc = o_wr_ready;
            @(posedge i_axi_aclk);
            #1;
            t++;
        end while (!acc && t < 100);
        check("beat_accept", acc, 1);
    endtask

    task automatic idle();
        i_wr_valid = 1'b0;
        i_wr_last  = 1'b0;
        i_wr_data  = 'x;
    endtask

    // Offers beats first..last (data = index, no last) for at most max_cyc clocks.
    task automatic stream(input int first, input int last_i, input int max_cyc,
                          output int acc_cnt, output int stall_cnt);
        logic acc;
        int   nxt;
        nxt        = first;
        acc_cnt    = 0;
        stall_cnt  = 0;
        i_wr_last  = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_data  = NDW'(nxt);
        for (int c = 0; c < max_cyc && nxt <= last_i; c++) begin
            @(negedge i_axi_aclk);
            acc = o_wr_ready;
            if (!acc) stall_cnt++;
            @(posedge i_axi_aclk);
            #1;
            if (acc) begin
                nxt++;
                acc_cnt++;
                i_wr_data = NDW'(nxt);
            end
        end
        idle();
    endtask

    task automatic expect_word(input string tag, input logic [WDW-1:0] d,
                               input logic [R-1:0] s, input logic l);
        word_t w;
        int    t;
        t = 0;
        while (got_q.size() == 0 && t < 50) begin
            @(posedge i_axi_aclk);
            #1;
            t++;
        end
        check({tag, "_avail"}, got_q.size() != 0, 1);
        if (got_q.size() != 0) begin
            w = got_q.pop_front();
            check({tag, "_data"}, w.d, d);
            check({tag, "_strb"}, w.s, s);
            check({tag, "_last"}, w.l, l);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, o_rd_valid, 0);
        check({tag, "_rd_data"},  o_rd_data,  0);
        check({tag, "_rd_strb"},  o_rd_strb,  0);
        check({tag, "_rd_last"},  o_rd_last,  0);
        check({tag, "_wr_ready"}, o_wr_ready, 0);
    endtask

    task automatic release_reset(input string tag);
        repeat (2) @(posedge i_axi_aclk);
        #3;
        i_axi_aresetn = 1'b1;
        #1;
        check({tag, "_rdy_after_release"}, o_wr_ready, 0);
        @(posedge i_axi_aclk);
        #1;
        check({tag, "_rdy_one_clk_later"}, o_wr_ready, 1);
    endtask

    initial begin
        i_rd_ready = 1'b1;
        idle();
        #2;
        check_reset_outputs("rst");
        release_reset("rst");

        // Full word, plus completion latency.
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        beat(32'h33, 1'b0);
        beat(32'h44, 1'b0);
        idle();
        check("t1_valid_at_k", o_rd_valid, 0);
        @(posedge i_axi_aclk);
        #1;
        check("t1_valid_at_k1", o_rd_valid, 1);
        expect_word("t1", {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 1'b0);

        // Early last on lane 1, then on lane 0, then on lane 3.
        beat(32'hA1, 1'b0);
        beat(32'hA2, 1'b1);
        idle();
        expect_word("t2", {64'h0, 32'hA2, 32'hA1}, 4'b0011, 1'b1);
        beat(32'hB1, 1'b1);
        idle();
        expect_word("t3", {96'h0, 32'hB1}, 4'b0001, 1'b1);
        beat(32'hC1, 1'b0);
        beat(32'hC2, 1'b0);
        beat(32'hC3, 1'b0);
        beat(32'hC4, 1'b1);
        idle();
        expect_word("t3b", {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'b1111, 1'b1);

        // Backpressure: two words held, then drain in order.
        i_rd_ready = 1'b0;
        stream(1, 12, 20, n_acc, n_stall);
        check("t4_accepted", n_acc, 8);
        check("t4_wr_ready_low", o_wr_ready, 0);
        check("t4_rd_valid", o_rd_valid, 1);
        check("t4_word0", o_rd_data, {32'd4, 32'd3, 32'd2, 32'd1});
        repeat (3) @(posedge i_axi_aclk);
        #1;
        check("t4_word0_stable", o_rd_data, {32'd4, 32'd3, 32'd2, 32'd1});
        check("t4_no_xfer", got_q.size(), 0);
        i_rd_ready = 1'b1;
        stream(9, 12, 50, n_acc, n_stall);
        check("t4_rest_accepted", n_acc, 4);
        expect_word("t4_w0", {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1111, 1'b0);
        expect_word("t4_w1", {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111, 1'b0);
        expect_word("t4_w2", {32'd12, 32'd11, 32'd10, 32'd9}, 4'b1111, 1'b0);

        // Zero-bubble streaming of 64 beats.
        stream(101, 164, 200, n_acc, n_stall);
        check("t5_accepted", n_acc, 64);
        check("t5_stalls", n_stall, 0);
        for (int w = 0; w < 16; w++) begin
            b = 101 + 4 * w;
            expect_word("t5", {NDW'(b + 3), NDW'(b + 2), NDW'(b + 1), NDW'(b)}, 4'b1111, 1'b0);
        end

        // Reset mid-word discards the partial accumulator.
        stream(1, 2, 10, n_acc, n_stall);
        check("t6_pre_accepted", n_acc, 2);
        i_axi_aresetn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        release_reset("t6");
        check("t6_no_output", got_q.size(), 0);
        stream(5, 8, 20, n_acc, n_stall);
        check("t6_accepted", n_acc, 4);
        expect_word("t6", {32'd8, 32'd7, 32'd6, 32'd5}, 4'b1111, 1'b0);
        repeat (5) @(posedge i_axi_aclk);
        #1;
        check("final_no_extra_words", got_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
